// File: rtl/tdc_meas_ctrl.sv
// rtl/tdc_meas_ctrl.sv - TDC measurement sequencer: arm over SPI, wait for intb, read TIME1/CAL1/CAL2, present result
//
// Ports:
//   clk, rst            system clock, asynchronous active-low reset
//   tdc_enable          TDC powered/booted; low forces IDLE
//   soft_reset          one-cycle pulse, aborts everything back to IDLE
//   play, pause         run control levels from the command decoder
//   tdc_intb            TDC interrupt (active-low, asynchronous)
//   spi_sclk/csn/mosi   SPI master (mode 0, MSB first), spi_miso from TDC DOUT
//   result_time1/cal1/cal2, result_valid, result_ready   result triple handshake
//   timeout             one-cycle pulse when intb never arrived
//   busy                high in every state except IDLE
module tdc_meas_ctrl #(
    parameter int         CLK_DIV     = 4,
    parameter logic [7:0] CONFIG1_VAL = 8'h03,
    parameter int         TIMEOUT_CYC = 200000,
    parameter int         GAP_CYC     = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tdc_enable,
    input  logic        soft_reset,
    input  logic        play,
    input  logic        pause,
    input  logic        tdc_intb,
    input  logic        spi_miso,
    output logic        spi_sclk,
    output logic        spi_csn,
    output logic        spi_mosi,
    output logic [23:0] result_time1,
    output logic [23:0] result_cal1,
    output logic [23:0] result_cal2,
    output logic        result_valid,
    input  logic        result_ready,
    output logic        timeout,
    output logic        busy
);

    localparam int DIV_W = $clog2(2 * CLK_DIV + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam int GAP_W = $clog2(GAP_CYC + 1);

    localparam logic [DIV_W-1:0] DIV_HALF  = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_SPACE = DIV_W'(2 * CLK_DIV - 1);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CYC - 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_ARM, ST_WAIT_INT, ST_RD_T1, ST_RD_C1, ST_RD_C2, ST_PRESENT, ST_GAP
    } state_t;

    // SPI transaction phases: csn setup, clocking, csn hold, csn-high spacing
    typedef enum logic [2:0] {
        PH_IDLE, PH_SETUP, PH_XFER, PH_HOLD, PH_SPACE
    } phase_t;

    state_t             state_q, state_d;
    phase_t             phase_q, phase_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [4:0]         bit_cnt_q, bit_cnt_d;
    logic               wr_q, wr_d;
    logic [31:0]        tx_q, tx_d;
    logic [23:0]        rx_q, rx_d;
    logic               sclk_q, sclk_d;
    logic               csn_q, csn_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [23:0]        t1_sh_q, t1_sh_d;
    logic [23:0]        c1_sh_q, c1_sh_d;
    logic [23:0]        res_t1_q, res_t1_d;
    logic [23:0]        res_c1_q, res_c1_d;
    logic [23:0]        res_c2_q, res_c2_d;
    logic               valid_q, valid_d;
    logic               timeout_q, timeout_d;
    logic               intb_s1_q, intb_s2_q;

    logic               start_req;
    logic               start_write;
    logic [7:0]         start_cmd;
    logic [7:0]         start_data;
    logic               xfer_done;
    logic               run_ok;
    logic               abort;

    assign xfer_done = (phase_q == PH_SPACE) && (div_q == DIV_SPACE);
    assign run_ok    = tdc_enable && play && !pause;
    assign abort     = soft_reset || !tdc_enable;

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        div_d       = div_q;
        bit_cnt_d   = bit_cnt_q;
        wr_d        = wr_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        sclk_d      = sclk_q;
        csn_d       = csn_q;
        tmo_d       = tmo_q;
        gap_d       = gap_q;
        t1_sh_d     = t1_sh_q;
        c1_sh_d     = c1_sh_q;
        res_t1_d    = res_t1_q;
        res_c1_d    = res_c1_q;
        res_c2_d    = res_c2_q;
        valid_d     = valid_q;
        timeout_d   = 1'b0;
        start_req   = 1'b0;
        start_write = 1'b0;
        start_cmd   = 8'h00;
        start_data  = 8'h00;

        // SPI engine
        case (phase_q)
            PH_SETUP: begin
                // The first rise lands exactly one half-period after csn fell.
                if (div_q == DIV_HALF) begin
                    phase_d = PH_XFER;
                    div_d   = '0;
                    sclk_d  = 1'b1;
                    rx_d    = {rx_q[22:0], spi_miso};
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            PH_XFER: begin
                if (div_q == DIV_HALF) begin
                    div_d = '0;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                        rx_d   = {rx_q[22:0], spi_miso};
                    end else begin
                        sclk_d = 1'b0;
                        if (bit_cnt_q == (wr_q ? 5'd15 : 5'd31)) begin
                            phase_d = PH_HOLD;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 5'd1;
                            tx_d      = {tx_q[30:0], 1'b0};
                        end
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            PH_HOLD: begin
                if (div_q == DIV_HALF) begin
                    phase_d = PH_SPACE;
                    csn_d   = 1'b1;
                    div_d   = '0;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            PH_SPACE: begin
                if (div_q == DIV_SPACE) begin
                    phase_d = PH_IDLE;
                    div_d   = '0;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            default: ;
        endcase

        // Measurement sequencer
        case (state_q)
            ST_IDLE: begin
                if (run_ok) begin
                    state_d     = ST_ARM;
                    start_req   = 1'b1;
                    start_write = 1'b1;
                    start_cmd   = 8'h40;
                    start_data  = CONFIG1_VAL;
                end
            end
            ST_ARM: begin
                if (xfer_done) begin
                    state_d = ST_WAIT_INT;
                    tmo_d   = '0;
                end
            end
            ST_WAIT_INT: begin
                if (!intb_s2_q) begin
                    state_d   = ST_RD_T1;
                    start_req = 1'b1;
                    start_cmd = 8'h10;
                end else if (tmo_q == TMO_LAST) begin
                    state_d   = ST_GAP;
                    timeout_d = 1'b1;
                    gap_d     = '0;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            ST_RD_T1: begin
                if (xfer_done) begin
                    state_d   = ST_RD_C1;
                    t1_sh_d   = rx_q;
                    start_req = 1'b1;
                    start_cmd = 8'h1B;
                end
            end
            ST_RD_C1: begin
                if (xfer_done) begin
                    state_d   = ST_RD_C2;
                    c1_sh_d   = rx_q;
                    start_req = 1'b1;
                    start_cmd = 8'h1C;
                end
            end
            ST_RD_C2: begin
                if (xfer_done) begin
                    state_d  = ST_PRESENT;
                    res_t1_d = t1_sh_q;
                    res_c1_d = c1_sh_q;
                    res_c2_d = rx_q;
                    valid_d  = 1'b1;
                end
            end
            ST_PRESENT: begin
                if (result_ready) begin
                    state_d = ST_GAP;
                    valid_d = 1'b0;
                    gap_d   = '0;
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    if (run_ok) begin
                        state_d     = ST_ARM;
                        start_req   = 1'b1;
                        start_write = 1'b1;
                        start_cmd   = 8'h40;
                        start_data  = CONFIG1_VAL;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Launching a transaction overrides the engine's return to idle.
        if (start_req) begin
            phase_d   = PH_SETUP;
            csn_d     = 1'b0;
            sclk_d    = 1'b0;
            div_d     = '0;
            bit_cnt_d = '0;
            wr_d      = start_write;
            tx_d      = {start_cmd, start_data, 16'h0000};
            rx_d      = '0;
        end

        // Abort wins over everything, including a same-cycle handshake.
        if (abort) begin
            state_d   = ST_IDLE;
            phase_d   = PH_IDLE;
            csn_d     = 1'b1;
            sclk_d    = 1'b0;
            div_d     = '0;
            bit_cnt_d = '0;
            valid_d   = 1'b0;
            timeout_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            phase_q   <= PH_IDLE;
            div_q     <= '0;
            bit_cnt_q <= '0;
            wr_q      <= 1'b0;
            tx_q      <= '0;
            rx_q      <= '0;
            sclk_q    <= 1'b0;
            csn_q     <= 1'b1;
            tmo_q     <= '0;
            gap_q     <= '0;
            t1_sh_q   <= '0;
            c1_sh_q   <= '0;
            res_t1_q  <= '0;
            res_c1_q  <= '0;
            res_c2_q  <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            intb_s1_q <= 1'b1;
            intb_s2_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            div_q     <= div_d;
            bit_cnt_q <= bit_cnt_d;
            wr_q      <= wr_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            sclk_q    <= sclk_d;
            csn_q     <= csn_d;
            tmo_q     <= tmo_d;
            gap_q     <= gap_d;
            t1_sh_q   <= t1_sh_d;
            c1_sh_q   <= c1_sh_d;
            res_t1_q  <= res_t1_d;
            res_c1_q  <= res_c1_d;
            res_c2_q  <= res_c2_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
            intb_s1_q <= tdc_intb;
            intb_s2_q <= intb_s1_q;
        end
    end

    // MOSI only carries data while csn is low; it shifts on sclk falls.
    assign spi_mosi     = ((phase_q == PH_SETUP) || (phase_q == PH_XFER)) ? tx_q[31] : 1'b0;
    assign spi_sclk     = sclk_q;
    assign spi_csn      = csn_q;
    assign result_time1 = res_t1_q;
    assign result_cal1  = res_c1_q;
    assign result_cal2  = res_c2_q;
    assign result_valid = valid_q;
    assign timeout      = timeout_q;
    assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_tdc_meas_ctrl.sv
// tb/tb_tdc_meas_ctrl.sv - scoreboard bench for tdc_meas_ctrl with a TDC SPI slave model
module tb_tdc_meas_ctrl;

    localparam int DIV = 4;
    localparam int TMO = 100;
    localparam int GAP = 40;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        tdc_enable = 1'b0;
    logic        soft_reset = 1'b0;
    logic        play = 1'b0;
    logic        pause = 1'b0;
    logic        tdc_intb = 1'b1;
    logic        spi_miso = 1'b0;
    logic        spi_sclk, spi_csn, spi_mosi;
    logic [23:0] result_time1, result_cal1, result_cal2;
    logic        result_valid;
    logic        result_ready = 1'b0;
    logic        timeout, busy;

    tdc_meas_ctrl #(
        .CLK_DIV    (DIV),
        .CONFIG1_VAL(8'h03),
        .TIMEOUT_CYC(TMO),
        .GAP_CYC    (GAP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tdc_enable  (tdc_enable),
        .soft_reset  (soft_reset),
        .play        (play),
        .pause       (pause),
        .tdc_intb    (tdc_intb),
        .spi_miso    (spi_miso),
        .spi_sclk    (spi_sclk),
        .spi_csn     (spi_csn),
        .spi_mosi    (spi_mosi),
        .result_time1(result_time1),
        .result_cal1 (result_cal1),
        .result_cal2 (result_cal2),
        .result_valid(result_valid),
        .result_ready(result_ready),
        .timeout     (timeout),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard queues
    typedef struct {
        int         nbits;   // 0 = aborted transaction, length not checked
        logic [7:0] cmd;
        logic [7:0] data;
    } spi_exp_t;

    typedef struct {
        logic [23:0] t1;
        logic [23:0] c1;
        logic [23:0] c2;
    } res_exp_t;

    spi_exp_t exp_spi[$];
    res_exp_t exp_res[$];

    // TDC SPI slave model
    logic [23:0] reg_t1 = '0, reg_c1 = '0, reg_c2 = '0;
    logic [31:0] sh = '0;
    logic [23:0] dout = '0;
    logic [7:0]  cmd_cap = '0, data_cap = '0;
    int          cur_rises = 0;
    int          done_cnt = 0;
    int          csn_falls = 0;
    logic        active = 1'b0;

    function automatic logic [23:0] tdc_reg(input logic [7:0] c);
        case (c[5:0])
            6'h10:   return reg_t1;
            6'h1B:   return reg_c1;
            6'h1C:   return reg_c2;
            default: return 24'h0;
        endcase
    endfunction

    initial forever begin
        @(negedge spi_csn);
        active = 1'b1;
        cur_rises = 0;
        sh = '0;
        csn_falls++;
    end

    initial forever begin
        @(posedge spi_sclk);
        sh = {sh[30:0], spi_mosi};
        cur_rises++;
        if (cur_rises == 8)  cmd_cap = sh[7:0];
        if (cur_rises == 16) data_cap = sh[7:0];
    end

    initial forever begin
        @(negedge spi_sclk);
        if (active && cur_rises >= 8) begin
            if (cur_rises == 8) dout = tdc_reg(cmd_cap);
            spi_miso = dout[23];
            dout = {dout[22:0], 1'b0};
        end
    end

    // SPI monitor: compare each completed transaction against the expected queue
    initial forever begin
        spi_exp_t e;
        @(posedge spi_csn);
        if (active) begin
            active = 1'b0;
            spi_miso = 1'b0;
            done_cnt++;
            if (exp_spi.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spi_unexpected: got cmd %0h with no transaction expected", cmd_cap);
            end else begin
                e = exp_spi.pop_front();
                check($sformatf("spi%0d_cmd", done_cnt), 72'(cmd_cap), 72'(e.cmd));
                if (e.nbits != 0)
                    check($sformatf("spi%0d_len", done_cnt), 72'(cur_rises), 72'(e.nbits));
                if (e.nbits == 16)
                    check($sformatf("spi%0d_wdata", done_cnt), 72'(data_cap), 72'(e.data));
            end
        end
    end

    // Result monitor: pop and compare whenever a handshake is about to complete
    initial forever begin
        res_exp_t r;
        @(negedge clk);
        if (rst && result_valid && result_ready) begin
            if (exp_res.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL result_unexpected: got %0h with no result expected",
                         {result_time1, result_cal1, result_cal2});
            end else begin
                r = exp_res.pop_front();
                check("result_triple", {result_time1, result_cal1, result_cal2}, {r.t1, r.c1, r.c2});
            end
        end
    end

    task automatic push_write();
        spi_exp_t e;
        e.nbits = 16; e.cmd = 8'h40; e.data = 8'h03;
        exp_spi.push_back(e);
    endtask

    task automatic push_read(input logic [7:0] c, input int n);
        spi_exp_t e;
        e.nbits = n; e.cmd = c; e.data = 8'h00;
        exp_spi.push_back(e);
    endtask

    task automatic push_meas(input logic [23:0] t1, input logic [23:0] c1, input logic [23:0] c2);
        push_write();
        push_read(8'h10, 32);
        push_read(8'h1B, 32);
        push_read(8'h1C, 32);
    endtask

    task automatic wait_spi_done(input int target, input int budget, input string name);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, 72'(done_cnt >= target), 72'd1);
    endtask

    task automatic pulse_intb();
        tdc_intb = 1'b0;
        repeat (20) @(negedge clk);
        tdc_intb = 1'b1;
    endtask

    initial begin
        int cnt;
        int bad;
        int vseen;
        int falls0;
        res_exp_t r;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_csn", 72'(spi_csn), 72'd1);
        check("rst_sclk_mosi", 72'({spi_sclk, spi_mosi}), 72'd0);
        check("rst_flags", 72'({result_valid, timeout, busy}), 72'd0);
        check("rst_results", {result_time1, result_cal1, result_cal2}, 72'd0);

        // First measurement: arm write, then three reads
        rst = 1'b1;
        @(negedge clk);
        reg_t1 = 24'h0123AB; reg_c1 = 24'h000F00; reg_c2 = 24'h00A000;
        push_meas(reg_t1, reg_c1, reg_c2);
        r.t1 = 24'h0123AB; r.c1 = 24'h000F00; r.c2 = 24'h00A000;
        exp_res.push_back(r);
        tdc_enable = 1'b1; play = 1'b1; pause = 1'b0;
        wait_spi_done(1, 500, "arm_write_done");
        repeat (10) @(negedge clk);
        tdc_intb = 1'b0;
        cnt = 0;
        while (!result_valid && cnt < 1000) begin
            @(negedge clk);
            cnt++;
            if (cnt == 20) tdc_intb = 1'b1;
        end
        tdc_intb = 1'b1;
        check("present_latency_lt_850", 72'(cnt < 850), 72'd1);

        // Hold ready low for 50 cycles; outputs must stay put
        push_write();
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            if (!result_valid || result_time1 !== 24'h0123AB || result_cal1 !== 24'h000F00 ||
                result_cal2 !== 24'h00A000)
                bad++;
            @(negedge clk);
        end
        check("hold_stable_cycles_bad", 72'(bad), 72'd0);
        @(posedge clk);
        #1 result_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("valid_drop_after_hs", 72'(result_valid), 72'd0);
        cnt = 0;
        while (spi_csn && cnt < 5000) begin
            @(negedge clk);
            cnt++;
        end
        check("gap_to_next_arm", 72'(cnt), 72'(GAP));

        // No intb: timeout after the arm write, then re-arm
        wait_spi_done(5, 500, "tmo_arm_done");
        push_write();
        cnt = 0; vseen = 0;
        while (!timeout && cnt < 1000) begin
            @(negedge clk);
            cnt++;
            if (result_valid) vseen++;
        end
        check("timeout_cycle", 72'(cnt), 72'(2 * DIV + TMO));
        @(negedge clk);
        check("timeout_one_cycle", 72'(timeout), 72'd0);
        cnt = 1;
        while (spi_csn && cnt < 5000) begin
            @(negedge clk);
            cnt++;
            if (result_valid) vseen++;
            if (timeout) vseen++;
        end
        check("timeout_no_valid", 72'(vseen), 72'd0);
        check("timeout_rearm_gap", 72'(cnt), 72'(GAP));

        // Pause during RD_C1: result still delivered, then IDLE
        reg_t1 = 24'hABCDEF; reg_c1 = 24'h123456; reg_c2 = 24'h7FFFFF;
        push_read(8'h10, 32);
        push_read(8'h1B, 32);
        push_read(8'h1C, 32);
        r.t1 = 24'hABCDEF; r.c1 = 24'h123456; r.c2 = 24'h7FFFFF;
        exp_res.push_back(r);
        wait_spi_done(6, 500, "pause_arm_done");
        repeat (10) @(negedge clk);
        pulse_intb();
        wait_spi_done(7, 600, "pause_t1_done");
        repeat (50) @(negedge clk);
        check("pause_in_rd_c1_csn", 72'(spi_csn), 72'd0);
        pause = 1'b1;
        cnt = 0;
        while (exp_res.size() != 0 && cnt < 2000) begin
            @(negedge clk);
            cnt++;
        end
        check("pause_result_accepted", 72'(exp_res.size()), 72'd0);
        repeat (GAP + 5) @(negedge clk);
        check("pause_idle_busy", 72'(busy), 72'd0);
        falls0 = csn_falls;
        repeat (200) @(negedge clk);
        check("pause_no_csn_activity", 72'(csn_falls - falls0), 72'd0);
        check("pause_still_idle", 72'(busy), 72'd0);

        // soft_reset in the middle of the TIME1 read
        push_write();
        push_read(8'h10, 0);
        pause = 1'b0;
        wait_spi_done(10, 500, "sr_arm_done");
        repeat (10) @(negedge clk);
        tdc_intb = 1'b0;
        cnt = 0;
        while (!(spi_csn == 1'b0 && cur_rises >= 12) && cnt < 500) begin
            @(negedge clk);
            cnt++;
            if (cnt == 20) tdc_intb = 1'b1;
        end
        tdc_intb = 1'b1;
        check("sr_mid_read_reached", 72'(cnt < 500), 72'd1);
        soft_reset = 1'b1;
        play = 1'b0;
        @(negedge clk);
        soft_reset = 1'b0;
        check("sr_csn_sclk", 72'({spi_csn, spi_sclk}), 72'b10);
        check("sr_idle_valid", 72'({busy, result_valid}), 72'd0);
        check("sr_results_kept", {result_time1, result_cal1, result_cal2},
              {24'hABCDEF, 24'h123456, 24'h7FFFFF});
        repeat (20) @(negedge clk);
        check("sr_spi_count", 72'(done_cnt), 72'd11);

        // Asynchronous reset while PRESENT is holding a result
        result_ready = 1'b0;
        reg_t1 = 24'h111111; reg_c1 = 24'h222222; reg_c2 = 24'h333333;
        push_meas(reg_t1, reg_c1, reg_c2);
        play = 1'b1;
        wait_spi_done(12, 500, "ar_arm_done");
        repeat (10) @(negedge clk);
        pulse_intb();
        cnt = 0;
        while (!result_valid && cnt < 1000) begin
            @(negedge clk);
            cnt++;
        end
        check("ar_present_result", {result_time1, result_cal1, result_cal2},
              {24'h111111, 24'h222222, 24'h333333});
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("ar_csn_sclk_mosi", 72'({spi_csn, spi_sclk, spi_mosi}), 72'b100);
        check("ar_flags", 72'({result_valid, timeout, busy}), 72'd0);
        check("ar_results", {result_time1, result_cal1, result_cal2}, 72'd0);

        check("spi_queue_drained", 72'(exp_spi.size()), 72'd0);
        check("result_queue_drained", 72'(exp_res.size()), 72'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tdc_meas_ctrl.md
Name: tdc_meas_ctrl

Overview:
- Downstream of the host command decoder. Consumes its tdc_enable, soft_reset, play and pause outputs.
- Drives the TDC chip's SPI port. While playing, it repeatedly arms a measurement, waits for the TDC interrupt, then reads TIME1, CALIBRATION1 and CALIBRATION2.
- Presents each result triple through a valid/ready handshake to the result packer / UART TX path.

Parameters:
- CLK_DIV, 4: SPI half-period in clk cycles. sclk = clk/(2*CLK_DIV). Legal range >= 2.
- CONFIG1_VAL, 8'h03: value written to CONFIG1 (addr 0x00) to start a measurement. Bit0 = START_MEAS.
- TIMEOUT_CYC, 200000: clk cycles to wait for intb before abandoning the measurement.
- GAP_CYC, 1000: idle clk cycles between the end of one measurement cycle and the next arm.

Ports:
- clk in 1: system clock.
- rst in 1: asynchronous, active-low reset.
- tdc_enable in 1: TDC powered and booted; block is inert while low.
- soft_reset in 1: single-cycle pulse; abort any activity and return to IDLE.
- play in 1: level; run continuous measurements.
- pause in 1: level; finish the current cycle, then stop arming.
- tdc_intb in 1: TDC interrupt, active-low, asynchronous; 2-FF synchronised internally.
- spi_miso in 1: TDC DOUT.
- spi_sclk out 1: SPI clock, mode 0, idles low.
- spi_csn out 1: chip select, active-low.
- spi_mosi out 1: TDC DIN, MSB first.
- result_time1 out 24: TIME1 register.
- result_cal1 out 24: CALIBRATION1 register.
- result_cal2 out 24: CALIBRATION2 register.
- result_valid out 1: result triple available.
- result_ready in 1: consumer accepts the result.
- timeout out 1: one-cycle pulse when intb does not arrive in time.
- busy out 1: high in every state except IDLE.

Behaviour:
- Reset (rst=0, async): state=IDLE.
  - spi_csn=1, spi_sclk=0, spi_mosi=0.
  - result_* = 0, result_valid=0, timeout=0, busy=0.
  - All counters = 0.
- SPI transaction:
  - csn falls one half-period before the first sclk rise.
  - MOSI changes on sclk fall; MISO is sampled on sclk rise.
  - Command byte: bit7=0 (no auto-increment), bit6=RW (1=write), bits5:0=address.
  - Write = cmd + 1 data byte (16 sclks). Read = cmd + 3 data bytes (32 sclks), assembled MSB first.
  - csn returns high one half-period after the last sclk fall and stays high for at least 2*CLK_DIV cycles between transactions.
- States:
  - IDLE:
    - Go to ARM when tdc_enable & play & !pause.
    - Otherwise stay in IDLE.
  - ARM:
    - Write CONFIG1_VAL to 0x00, then go to WAIT_INT.
    - The timeout counter clears on entry.
  - WAIT_INT:
    - Synchronised intb low -> RD_T1.
    - Counter reaches TIMEOUT_CYC-1 -> pulse timeout for one cycle and go to GAP. No result is produced.
  - RD_T1: read 0x10 into the time1 shadow, then go to RD_C1.
  - RD_C1: read 0x1B into the cal1 shadow, then go to RD_C2.
  - RD_C2: read 0x1C into the cal2 shadow, then go to PRESENT.
  - PRESENT:
    - Copy the shadows to result_* and assert result_valid.
    - Hold result_* and result_valid stable until result_valid & result_ready is sampled on a clk edge.
    - That edge deasserts valid and moves to GAP.
  - GAP:
    - Count GAP_CYC cycles, then go to ARM if play & !pause & tdc_enable; else go to IDLE.
- pause or play deasserting mid-cycle does not abort the cycle. The current measurement completes and presents its result.
- soft_reset (or tdc_enable low) in any state, in the next cycle:
  - state=IDLE, csn=1, sclk=0, result_valid=0.
  - The partial transaction is discarded and result_* keep their last values.
  - soft_reset has priority over every other transition, including a simultaneous handshake.
- An intb low that arrives before WAIT_INT is entered is ignored. intb is only checked in WAIT_INT, after the ARM write completes.
- result_ready while result_valid=0 has no effect.
- Latency after intb falls, with CLK_DIV=4:
  - 2 sync cycles, then 3 reads of 32*8 cycles each plus csn setup/hold and gaps.
  - PRESENT must be reached within 850 clk cycles.

Test Plan:
- Reset, then tdc_enable=1, play=1, pause=0: csn falls and MOSI carries 0x40,0x03. Then intb=0 with the SPI model returning 0x0123AB, 0x000F00, 0x00A000: result_time1=0x0123AB, result_cal1=0x000F00, result_cal2=0x00A000, result_valid=1.
- Hold result_ready=0 for 50 cycles, then 1: outputs stay stable throughout; valid drops the cycle after the handshake edge; the next ARM starts GAP_CYC cycles later.
- Run with TIMEOUT_CYC=100 and never assert intb: exactly one timeout pulse at cycle 100 after WAIT_INT entry, no result_valid, then the block re-arms.
- Assert pause during RD_C1: the current result is still presented and accepted, then the block returns to IDLE with busy=0 and no further csn activity.
- Pulse soft_reset mid-RD_T1 (sclk toggling): the next cycle shows csn=1, sclk=0, state IDLE, result_valid=0, and the prior result_* are unchanged.
- Assert rst=0 asynchronously between clk edges during PRESENT: all outputs take their reset values immediately, without waiting for a clk edge.
